// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: responder side of the DMA bus handshake.
// The CPU owns the shared BRAM/peripheral bus until a DMA request arrives.
// On a request the arbiter stalls the core, waits for a safe point, and then
// grants the bus. It takes the bus back on done, on request drop, or at the
// burst limit. After each handback the CPU keeps the bus for a minimum window.
// Every output is a register or a decode of registered state, so no input
// reaches an output combinationally.
module dma_bus_arbiter #(
  parameter int MAX_BURST     = 256,
  parameter int CPU_MIN_SLOTS = 4,
  parameter int CNT_W         = 9
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Dma_Req,
  input  logic             i_Dma_Done,
  input  logic             i_Cpu_Idle,
  output logic             o_Cpu_Stall,
  output logic             o_Bus_Grant,
  output logic             o_Bus_Owner,
  output logic             o_Preempt,
  output logic [1:0]       o_State,
  output logic [CNT_W-1:0] o_Grant_Count
);

  typedef enum logic [1:0] {
    CPU_OWN  = 2'b00,
    DRAIN    = 2'b01,
    DMA_OWN  = 2'b10,
    HANDBACK = 2'b11
  } state_e;

  // The cooldown counter only has to hold CPU_MIN_SLOTS.
  localparam int COOL_W = (CPU_MIN_SLOTS < 1) ? 1 : $clog2(CPU_MIN_SLOTS + 1);

  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(CPU_MIN_SLOTS);
  localparam logic [COOL_W-1:0] COOL_ZERO = {COOL_W{1'b0}};
  localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  BURST_LIM = CNT_W'(MAX_BURST);

  state_e             state_q, state_d;
  logic [COOL_W-1:0]  cool_q, cool_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               preempt_q, preempt_d;

  // Next-state logic for state, cooldown, grant counter and preempt pulse.
  always_comb begin
    state_d   = state_q;
    cool_d    = cool_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;
    case (state_q)
      CPU_OWN: begin
        // Requests are level-held, so holding one off during cooldown loses nothing.
        if (cool_q != COOL_ZERO) begin
          cool_d = cool_q - COOL_ONE;
        end else if (i_Dma_Req) begin
          state_d = DRAIN;
        end else begin
          state_d = CPU_OWN;
        end
      end
      DRAIN: begin
        // An aborted request takes priority over the core reaching a safe point.
        if (!i_Dma_Req) begin
          state_d = HANDBACK;
        end else if (i_Cpu_Idle) begin
          state_d = DMA_OWN;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DMA_OWN: begin
        // A normal end (done or request drop) is never reported as a preemption,
        // even when it lands on the same cycle as the burst limit.
        if (i_Dma_Done || !i_Dma_Req) begin
          state_d = HANDBACK;
        end else if (cnt_q == BURST_LIM) begin
          state_d   = HANDBACK;
          preempt_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HANDBACK: begin
        // Spend one bus-turnaround cycle here, then guarantee the CPU its minimum window.
        state_d = CPU_OWN;
        cool_d  = COOL_LOAD;
      end
      default: begin
        state_d = CPU_OWN;
        cool_d  = COOL_ZERO;
      end
    endcase
  end

  // State and counter registers. Reset clears them at once, which also drops every output.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q   <= CPU_OWN;
      cool_q    <= COOL_ZERO;
      cnt_q     <= CNT_ZERO;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cool_q    <= cool_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  // Outputs are decoded only from registered state.
  assign o_State       = state_q;
  assign o_Cpu_Stall   = (state_q != CPU_OWN);
  assign o_Bus_Grant   = (state_q == DMA_OWN);
  assign o_Bus_Owner   = state_q[1];
  assign o_Preempt     = preempt_q;
  assign o_Grant_Count = cnt_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed, scoreboard-checked bench for dma_bus_arbiter.
// The burst limit is set to 12 so that a single instance covers three cases:
// done on the 10th grant cycle, a forced preemption, and done coinciding with
// the limit.
module tb_dma_bus_arbiter;

  localparam int TB_MAX_BURST = 12;
  localparam int TB_MIN_SLOTS = 4;
  localparam int CNT_W        = 9;
  localparam int OBS_W        = 6 + CNT_W;

  logic             clk;
  logic             rst_n;
  logic             dma_req;
  logic             dma_done;
  logic             cpu_idle;
  logic             cpu_stall;
  logic             bus_grant;
  logic             bus_owner;
  logic             preempt;
  logic [1:0]       state;
  logic [CNT_W-1:0] grant_count;
  logic [OBS_W-1:0] obs;

  typedef struct {
    string            tag;
    logic [OBS_W-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt  = 0;
  int   fail_cnt = 0;

  dma_bus_arbiter #(
    .MAX_BURST    (TB_MAX_BURST),
    .CPU_MIN_SLOTS(TB_MIN_SLOTS),
    .CNT_W        (CNT_W)
  ) u_dut (
    .i_Clock      (clk),
    .i_Reset      (rst_n),
    .i_Dma_Req    (dma_req),
    .i_Dma_Done   (dma_done),
    .i_Cpu_Idle   (cpu_idle),
    .o_Cpu_Stall  (cpu_stall),
    .o_Bus_Grant  (bus_grant),
    .o_Bus_Owner  (bus_owner),
    .o_Preempt    (preempt),
    .o_State      (state),
    .o_Grant_Count(grant_count)
  );

  assign obs = {state, cpu_stall, bus_grant, bus_owner, preempt, grant_count};

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation vector. The stall/grant/owner bits come from the state table.
  function automatic logic [OBS_W-1:0] exp_obs(input logic [1:0] st, input int cnt, input logic pre);
    logic stall_e;
    logic grant_e;
    logic owner_e;
    stall_e = (st != 2'b00);
    grant_e = (st == 2'b10);
    owner_e = st[1];
    return {st, stall_e, grant_e, owner_e, pre, CNT_W'(cnt)};
  endfunction

  task automatic push_exp(input string tag, input logic [1:0] st, input int cnt, input logic pre);
    exp_t e;
    e.tag = tag;
    e.val = exp_obs(st, cnt, pre);
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      cmp_cnt++;
      fail_cnt++;
      $error("FAIL scoreboard_empty: observed %h expected an entry", obs);
    end else begin
      e = sb.pop_front();
      cmp_cnt++;
      assert (obs === e.val) else begin
        fail_cnt++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs, then compare.
  task automatic cyc(input logic req, input logic done, input logic idle,
                     input logic [1:0] st, input int cnt, input logic pre, input string tag);
    dma_req  = req;
    dma_done = done;
    cpu_idle = idle;
    push_exp(tag, st, cnt, pre);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n    = 1'b0;
    dma_req  = 1'b0;
    dma_done = 1'b0;
    cpu_idle = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 2'b00, 0, 1'b0);
    check_out();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, "idle_after_reset");

    // Request with core idle: stall one edge later, grant two edges later
    cyc(1'b1, 1'b0, 1'b1, 2'b01, 0, 1'b0, "req_to_drain");
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, "first_grant");
    for (int i = 2; i <= 10; i++) cyc(1'b1, 1'b0, 1'b1, 2'b10, i, 1'b0, "grant_count");
    // Done on the 10th grant cycle
    cyc(1'b1, 1'b1, 1'b1, 2'b11, 10, 1'b0, "done_handback");
    cyc(1'b1, 1'b0, 1'b1, 2'b00, 10, 1'b0, "cpu_back");
    for (int i = 0; i < TB_MIN_SLOTS; i++) cyc(1'b1, 1'b0, 1'b1, 2'b00, 10, 1'b0, "cooldown_hold");
    cyc(1'b1, 1'b0, 1'b1, 2'b01, 10, 1'b0, "cooldown_drain");
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, "regrant_after_done");
    // Request drop ends the grant without a preempt
    cyc(1'b0, 1'b0, 1'b1, 2'b11, 1, 1'b0, "req_drop_handback");
    cyc(1'b0, 1'b0, 1'b1, 2'b00, 1, 1'b0, "req_drop_cpu");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00, 1, 1'b0, "quiet1");

    // Core busy: stay in DRAIN until idle rises
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 1, 1'b0, "drain_enter");
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 2'b01, 1, 1'b0, "drain_hold");
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, "idle_grant");
    // Burst limit reached: preempt pulse, count held
    for (int i = 2; i <= TB_MAX_BURST; i++) cyc(1'b1, 1'b0, 1'b1, 2'b10, i, 1'b0, "burst_count");
    cyc(1'b1, 1'b0, 1'b1, 2'b11, TB_MAX_BURST, 1'b1, "preempt_pulse");
    cyc(1'b1, 1'b0, 1'b1, 2'b00, TB_MAX_BURST, 1'b0, "preempt_end");
    for (int i = 0; i < TB_MIN_SLOTS; i++) cyc(1'b1, 1'b0, 1'b1, 2'b00, TB_MAX_BURST, 1'b0, "preempt_cooldown");
    cyc(1'b1, 1'b0, 1'b1, 2'b01, TB_MAX_BURST, 1'b0, "preempt_redrain");
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, "regrant_after_preempt");
    // Done on the same cycle as the limit: no preempt
    for (int i = 2; i <= TB_MAX_BURST; i++) cyc(1'b1, 1'b0, 1'b1, 2'b10, i, 1'b0, "burst_count2");
    cyc(1'b1, 1'b1, 1'b1, 2'b11, TB_MAX_BURST, 1'b0, "done_at_limit");
    cyc(1'b0, 1'b0, 1'b1, 2'b00, TB_MAX_BURST, 1'b0, "done_at_limit_cpu");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00, TB_MAX_BURST, 1'b0, "quiet2");

    // Aborted DRAIN leaves the grant count untouched
    cyc(1'b1, 1'b0, 1'b0, 2'b01, TB_MAX_BURST, 1'b0, "abort_drain");
    cyc(1'b0, 1'b0, 1'b0, 2'b11, TB_MAX_BURST, 1'b0, "abort_handback");
    cyc(1'b0, 1'b0, 1'b0, 2'b00, TB_MAX_BURST, 1'b0, "abort_cpu");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00, TB_MAX_BURST, 1'b0, "quiet3");

    // Asynchronous reset in the middle of a grant
    cyc(1'b1, 1'b0, 1'b1, 2'b01, TB_MAX_BURST, 1'b0, "pre_reset_drain");
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 1, 1'b0, "pre_reset_grant1");
    cyc(1'b1, 1'b0, 1'b1, 2'b10, 2, 1'b0, "pre_reset_grant2");
    #2;
    rst_n = 1'b0;
    push_exp("async_reset", 2'b00, 0, 1'b0);
    #1;
    check_out();
    @(posedge clk);
    #1;
    push_exp("reset_held", 2'b00, 0, 1'b0);
    check_out();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 2'b01, 0, 1'b0, "post_reset_drain");
    cyc(1'b0, 1'b0, 1'b0, 2'b11, 0, 1'b0, "post_reset_abort");
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, "post_reset_count_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Responder side of the DMA bus handshake. It owns the shared BRAM/peripheral bus on behalf of the CPU core.
- On a DMA request it stalls the core, waits for the core to reach a safe point, then grants the bus to the DMA controller (drives the controller's i_Bus_Grant).
- It reclaims the bus when the transfer completes, when the request drops, or when the burst limit expires.
- After each grant it enforces a minimum CPU window so the core cannot be starved.

Parameters:
- MAX_BURST, 256: maximum consecutive cycles a grant may stay high before forced preemption (>=2).
- CPU_MIN_SLOTS, 4: cycles the CPU keeps the bus after a handback before a new request is honoured (>=1).
- CNT_W, 9: width of the grant cycle counter; must hold MAX_BURST.

Ports:
- i_Clock  in  1  system clock, all logic on the rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_Dma_Req  in  1  level request from the DMA controller; held high for the whole transfer.
- i_Dma_Done  in  1  one-cycle pulse from the DMA controller: transfer complete.
- i_Cpu_Idle  in  1  core has no outstanding memory access (safe to stall).
- o_Cpu_Stall  out  1  freezes the core pipeline.
- o_Bus_Grant  out  1  grant to the DMA controller.
- o_Bus_Owner  out  1  bus mux select: 0 = CPU, 1 = DMA.
- o_Preempt  out  1  one-cycle pulse: grant revoked by the burst limit.
- o_State  out  2  current state, for debug.
- o_Grant_Count  out  CNT_W  cycles o_Bus_Grant was high in the current or most recent grant.

Behaviour:
- Reset (i_Reset=0, asynchronous):
  - State = CPU_OWN, cooldown counter = 0, o_Grant_Count = 0.
  - All outputs = 0 immediately, including mid-grant. The DMA controller sees the grant drop in the same cycle.
- All outputs are registered or decoded directly from registered state. No combinational path from any input to any output.
- States (o_State encoding):
  - CPU_OWN (00): stall=0, grant=0, owner=0.
    - Cooldown decrements by 1 per cycle while nonzero.
    - If i_Dma_Req=1 and cooldown=0 -> DRAIN.
    - Requests while cooldown≠0 are held off; they are not lost because the request is a level.
  - DRAIN (01): stall=1, grant=0, owner=0.
    - If i_Dma_Req=0 -> HANDBACK (request abort). This check has priority over i_Cpu_Idle.
    - Else if i_Cpu_Idle=1 -> DMA_OWN.
    - Else stay, with no timeout.
  - DMA_OWN (10): stall=1, grant=1, owner=1.
    - o_Grant_Count is cleared to 1 on entry and increments each further cycle in the state. Saturating is not needed because the limit exits first.
    - Exit priority: (1) i_Dma_Done=1 or i_Dma_Req=0 -> HANDBACK, no preempt. (2) o_Grant_Count = MAX_BURST -> HANDBACK with o_Preempt=1 for exactly one cycle, the cycle in HANDBACK.
  - HANDBACK (11): stall=1, grant=0, owner=1 (one bus-turnaround cycle).
    - Unconditional -> CPU_OWN; cooldown loaded with CPU_MIN_SLOTS.
    - i_Dma_Req is ignored in this state.
- Latency:
  - Request sampled in CPU_OWN at edge N -> o_Cpu_Stall=1 after edge N.
  - With i_Cpu_Idle=1 sampled at edge N+1 -> o_Bus_Grant=1 after edge N+1. Minimum request-to-grant is 2 cycles.
  - Done sampled at edge M -> grant=0 after edge M; o_Cpu_Stall=0 and owner=0 after edge M+1.
- Cooldown: a request held continuously after handback gets its next grant no earlier than CPU_MIN_SLOTS+2 cycles after HANDBACK exits.
- o_Grant_Count holds its value after the grant ends until the next DMA_OWN entry. It stays 0 after reset and after an aborted DRAIN.
- Invariants:
  - o_Bus_Grant=1 implies o_Cpu_Stall=1 and o_Bus_Owner=1.
  - o_Bus_Grant never stays high longer than MAX_BURST cycles.
  - A preempted transfer that keeps i_Dma_Req high is re-granted after cooldown, with o_Grant_Count restarting at 1.

Test Plan:
- Reset sequence, then i_Dma_Req=1 with i_Cpu_Idle=1 -> o_Cpu_Stall high 1 cycle after the request edge and o_Bus_Grant high 2 cycles after. o_State goes 00→01→10.
- i_Cpu_Idle held 0 for 5 cycles with the request asserted -> stays in DRAIN for 5 cycles, grant 0, stall 1. Grant follows 1 cycle after Idle rises.
- Granted, i_Dma_Done pulse on the 10th grant cycle -> grant drops next edge, o_Grant_Count=10, HANDBACK for 1 cycle, then stall=0. A request held high is re-granted no earlier than 6 cycles (CPU_MIN_SLOTS=4) after HANDBACK exits.
- MAX_BURST=8, request held, no done -> grant high exactly 8 cycles, o_Preempt one-cycle pulse, o_Grant_Count=8, re-grant after cooldown with count restarting at 1.
- i_Dma_Done and the burst limit in the same cycle (MAX_BURST=8, done on cycle 8) -> HANDBACK with o_Preempt=0.
- i_Reset driven low mid-grant between clock edges -> o_Bus_Grant, o_Cpu_Stall and o_Bus_Owner go 0 without waiting for a clock edge; after release, o_State=00 and o_Grant_Count=0.
- Request dropped while in DRAIN -> HANDBACK then CPU_OWN, grant never asserted, o_Grant_Count unchanged.
